perf_csr_file: RTL

PERF_CSR_FILE -- requirements
Module: perf_csr_file

---
 rtl/perf_csr_file.sv | 118 +++++++++++
 1 files changed

// File: rtl/perf_csr_file.sv
// Performance counter CSR file: NUM_CNT event counters of CNT_W bits each,
// with per-counter inhibit, sticky overflow status (write-1-to-clear),
// overflow interrupt enable, and a high-half shadow register so that a
// low-then-high read pair sees a consistent counter value.
module perf_csr_file #(
  parameter int NUM_CNT = 8,
  parameter int CNT_W   = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] events,
  input  logic               wEn,
  input  logic [11:0]        wAddr,
  input  logic [31:0]        wData,
  input  logic               rdEn,
  input  logic [11:0]        rdAddr,
  output logic [31:0]        rdData,
  output logic               rdHit,
  output logic [NUM_CNT-1:0] ovfFlags,
  output logic               ovfIrq
);

  localparam int HI_W = CNT_W - 32;

  localparam logic [11:0] ADDR_INHIBIT = 12'h020;
  localparam logic [11:0] ADDR_STATUS  = 12'h021;
  localparam logic [11:0] ADDR_OVF_EN  = 12'h022;

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] inhibit_q, inhibit_d;
  logic [NUM_CNT-1:0] ovf_en_q, ovf_en_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [HI_W-1:0]    shadow_q, shadow_d;
  logic [NUM_CNT-1:0] ovf_set;
  logic [NUM_CNT-1:0] w1c_mask;

  // Counter update: a CSR write to either half takes priority and swallows
  // that cycle's event; otherwise an uninhibited event increments and flags
  // overflow when the counter wraps from all-ones.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (wEn && (wAddr[11:1] == 11'(i))) begin
        if (!wAddr[0]) begin
          cnt_d[i][31:0] = wData;
        end else begin
          cnt_d[i][CNT_W-1:32] = wData[HI_W-1:0];
        end
      end else if (events[i] && !inhibit_q[i]) begin
        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        ovf_set[i] = &cnt_q[i];
      end
    end
  end

  // Control registers and sticky status; a fresh overflow beats a W1C clear.
  always_comb begin
    w1c_mask  = (wEn && (wAddr == ADDR_STATUS)) ? wData[NUM_CNT-1:0] : '0;
    ovf_d     = (ovf_q & ~w1c_mask) | ovf_set;
    inhibit_d = (wEn && (wAddr == ADDR_INHIBIT)) ? wData[NUM_CNT-1:0] : inhibit_q;
    ovf_en_d  = (wEn && (wAddr == ADDR_OVF_EN)) ? wData[NUM_CNT-1:0] : ovf_en_q;
  end

  // Shadow capture: a qualified low-half read latches that counter's high bits.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rdEn && !rdAddr[0] && (rdAddr[11:1] == 11'(i))) begin
        shadow_d = cnt_q[i][CNT_W-1:32];
      end
    end
  end

  // Combinational read mux; high halves return the shadow, not the live bits.
  always_comb begin
    rdData = '0;
    rdHit  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rdAddr[11:1] == 11'(i)) begin
        rdHit  = 1'b1;
        rdData = rdAddr[0] ? 32'(shadow_q) : cnt_q[i][31:0];
      end
    end
    case (rdAddr)
      ADDR_INHIBIT: begin rdHit = 1'b1; rdData = 32'(inhibit_q); end
      ADDR_STATUS:  begin rdHit = 1'b1; rdData = 32'(ovf_q);     end
      ADDR_OVF_EN:  begin rdHit = 1'b1; rdData = 32'(ovf_en_q);  end
      default: ;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      inhibit_q <= '0;
      ovf_en_q  <= '0;
      ovf_q     <= '0;
      shadow_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      inhibit_q <= inhibit_d;
      ovf_en_q  <= ovf_en_d;
      ovf_q     <= ovf_d;
      shadow_q  <= shadow_d;
    end
  end

  assign ovfFlags = ovf_q;
  assign ovfIrq   = |(ovf_q & ovf_en_q);

endmodule
